// File: rtl/hb_ram_arbiter.sv
// Shares the single-port data RAM between the core load/store port (fixed priority)
// and an auxiliary req/gnt master, with an aging counter that forces aux through.
module hb_ram_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [1:0]  core_wwidth,
  input  logic [31:0] core_raddr,
  input  logic [31:0] core_waddr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall_req,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [1:0]  aux_wwidth,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [1:0]  ram_wwidth,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {ST_CORE, ST_CORE_RD, ST_AUX_FORCE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_AUX} owner_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  owner_t      rd_owner_q, rd_owner_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] hold_q, hold_d;

  logic core_sel;
  logic core_wr_sel;
  logic aux_sel;

  always_comb begin
    state_d        = state_q;
    core_sel       = 1'b0;
    core_wr_sel    = 1'b0;
    aux_sel        = 1'b0;
    core_stall_req = 1'b0;
    unique case (state_q)
      ST_CORE: begin
        if (core_write) begin
          core_sel       = 1'b1;
          core_wr_sel    = 1'b1;
          core_stall_req = core_read;
          if (core_read) state_d = ST_CORE_RD;
        end else if (core_read) begin
          core_sel = 1'b1;
        end else if (aux_req) begin
          aux_sel = 1'b1;
        end
      end
      ST_CORE_RD: begin
        core_sel = core_read;
        state_d  = ST_CORE;
      end
      ST_AUX_FORCE: begin
        aux_sel        = aux_req;
        core_stall_req = core_read | core_write;
        state_d        = ST_CORE;
      end
      default: state_d = ST_CORE;
    endcase

    if (!aux_req || aux_sel) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q != MAX_W) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // Forcing only from a plain CORE cycle: an open read+write pair finishes first,
    // and the cycle after a forced turn is always a normal CORE cycle.
    if (state_q == ST_CORE && state_d == ST_CORE && wait_cnt_d == MAX_W) begin
      state_d = ST_AUX_FORCE;
    end
  end

  always_comb begin
    ram_en     = core_sel | aux_sel;
    ram_we     = 1'b0;
    ram_wwidth = 2'd0;
    ram_addr   = 32'd0;
    ram_wdata  = 32'd0;
    if (core_sel) begin
      ram_we   = core_wr_sel;
      ram_addr = core_wr_sel ? core_waddr : core_raddr;
      if (core_wr_sel) begin
        ram_wwidth = core_wwidth;
        ram_wdata  = core_wdata;
      end
    end else if (aux_sel) begin
      ram_we     = aux_we;
      ram_wwidth = aux_wwidth;
      ram_addr   = aux_addr;
      ram_wdata  = aux_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (ram_en && !ram_we) begin
      rd_owner_d = core_sel ? OWN_CORE : OWN_AUX;
    end
    hold_d = (rd_owner_q == OWN_CORE) ? ram_rdata : hold_q;
  end

  assign aux_gnt    = aux_sel;
  assign aux_rvalid = (rd_owner_q == OWN_AUX);
  assign aux_rdata  = ram_rdata;
  // Load data stays visible to the core across later stall cycles.
  assign core_rdata = (rd_owner_q == OWN_CORE) ? ram_rdata : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CORE;
      rd_owner_q <= OWN_NONE;
      wait_cnt_q <= 8'd0;
      hold_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
    end
  end

endmodule
